vector_register_file: RTL and testbench

Parametrised multi-lane register file for the vector datapath. It is the successor to the scalar register file and is generalised to NUM_REGS registers of LANES x LANE_WIDTH bits. It adds per-lane write masking, registered read ports with write bypass, an optional hardwired zero register, and a busy scoreboard for multi-cycle producers. It sits between decode (read and reserve) and writeback (write/clear).

---
 rtl/vector_register_file.sv | 133 +++++++++++++
 tb/tb_vector_register_file.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vector_register_file.sv
`default_nettype none
// ============================================================================
// Module   : vector_register_file
// Brief    : Multi-lane register file with masked writes, bypassed registered
//            read ports, optional zero register and a busy scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module vector_register_file #(
  parameter int NUM_REGS   = 8,
  parameter int LANES      = 4,
  parameter int LANE_WIDTH = 8,
  parameter bit ZERO_REG   = 1'b1,
  localparam int IW        = $clog2(NUM_REGS),
  localparam int W         = LANES * LANE_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          regWrEn,
  input  logic [IW-1:0] regToWrite,
  input  logic [LANES-1:0] wrMask,
  input  logic [W-1:0]  dataIn,
  input  logic          rdEn,
  input  logic [IW-1:0] rSel1,
  input  logic [IW-1:0] rSel2,
  output logic [W-1:0]  reg1Out,
  output logic [W-1:0]  reg2Out,
  output logic          busy1,
  output logic          busy2,
  input  logic          reserveEn,
  input  logic [IW-1:0] regToReserve,
  output logic          reserveErr
);

  localparam logic [IW:0] c_NUM_REGS = (IW+1)'(NUM_REGS);

  logic [W-1:0]        r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [W-1:0]        r_rd1_data;
  logic [W-1:0]        r_rd2_data;
  logic                r_rd1_busy;
  logic                r_rd2_busy;
  logic                r_res_err;

  logic                w_wr_ok;
  logic                w_res_ok;
  logic                w_res_err;
  logic [W-1:0]        w_wr_old;
  logic [W-1:0]        w_wr_merged;
  logic [NUM_REGS-1:0] w_busy_next;
  logic [W-1:0]        w_rd1_data;
  logic [W-1:0]        w_rd2_data;
  logic                w_rd1_busy;
  logic                w_rd2_busy;

  // Index addresses real, writable storage: in range and not the zero register.
  function automatic logic idx_ok(input logic [IW-1:0] idx);
    return ({1'b0, idx} < c_NUM_REGS) && !(ZERO_REG && (idx == '0));
  endfunction

  always_comb begin
    w_wr_ok   = regWrEn && idx_ok(regToWrite);
    w_res_ok  = reserveEn && idx_ok(regToReserve);
    w_res_err = w_res_ok && r_busy[regToReserve] &&
                !(w_wr_ok && (regToWrite == regToReserve));
    w_wr_old  = w_wr_ok ? r_regs[regToWrite] : '0;
    w_wr_merged = w_wr_old;
    for (int l = 0; l < LANES; l++) begin
      if (wrMask[l]) begin
        w_wr_merged[l*LANE_WIDTH +: LANE_WIDTH] = dataIn[l*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  // A same-edge reservation overrides the clear from a write.
  always_comb begin
    w_busy_next = r_busy;
    if (w_wr_ok) begin
      w_busy_next[regToWrite] = 1'b0;
    end
    if (w_res_ok && !w_res_err) begin
      w_busy_next[regToReserve] = 1'b1;
    end
  end

  always_comb begin
    w_rd1_data = '0;
    w_rd1_busy = 1'b0;
    w_rd2_data = '0;
    w_rd2_busy = 1'b0;
    if (idx_ok(rSel1)) begin
      w_rd1_data = (w_wr_ok && (regToWrite == rSel1)) ? w_wr_merged : r_regs[rSel1];
      w_rd1_busy = w_busy_next[rSel1];
    end
    if (idx_ok(rSel2)) begin
      w_rd2_data = (w_wr_ok && (regToWrite == rSel2)) ? w_wr_merged : r_regs[rSel2];
      w_rd2_busy = w_busy_next[rSel2];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= '0;
      end
      r_busy     <= '0;
      r_rd1_data <= '0;
      r_rd2_data <= '0;
      r_rd1_busy <= 1'b0;
      r_rd2_busy <= 1'b0;
      r_res_err  <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_regs[regToWrite] <= w_wr_merged;
      end
      r_busy    <= w_busy_next;
      r_res_err <= w_res_err;
      if (rdEn) begin
        r_rd1_data <= w_rd1_data;
        r_rd2_data <= w_rd2_data;
        r_rd1_busy <= w_rd1_busy;
        r_rd2_busy <= w_rd2_busy;
      end
    end
  end

  assign reg1Out    = r_rd1_data;
  assign reg2Out    = r_rd2_data;
  assign busy1      = r_rd1_busy;
  assign busy2      = r_rd2_busy;
  assign reserveErr = r_res_err;

endmodule
`default_nettype wire

// File: tb/tb_vector_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_register_file
// Brief    : Directed plus randomized bench for vector_register_file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_register_file;

  localparam int NR = 8;
  localparam int LN = 4;
  localparam int LW = 8;
  localparam int IW = 3;
  localparam int W  = LN * LW;

  logic          clk = 1'b0;
  logic          reset;
  logic          regWrEn;
  logic [IW-1:0] regToWrite;
  logic [LN-1:0] wrMask;
  logic [W-1:0]  dataIn;
  logic          rdEn;
  logic [IW-1:0] rSel1;
  logic [IW-1:0] rSel2;
  logic [W-1:0]  reg1Out;
  logic [W-1:0]  reg2Out;
  logic          busy1;
  logic          busy2;
  logic          reserveEn;
  logic [IW-1:0] regToReserve;
  logic          reserveErr;

  always #5 clk = ~clk;

  vector_register_file #(
    .NUM_REGS  (NR),
    .LANES     (LN),
    .LANE_WIDTH(LW),
    .ZERO_REG  (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .regWrEn     (regWrEn),
    .regToWrite  (regToWrite),
    .wrMask      (wrMask),
    .dataIn      (dataIn),
    .rdEn        (rdEn),
    .rSel1       (rSel1),
    .rSel2       (rSel2),
    .reg1Out     (reg1Out),
    .reg2Out     (reg2Out),
    .busy1       (busy1),
    .busy2       (busy2),
    .reserveEn   (reserveEn),
    .regToReserve(regToReserve),
    .reserveErr  (reserveErr)
  );

  // Reference state: architectural contents and pending flags per register.
  logic [W-1:0] m_mem  [NR];
  logic         m_busy [NR];
  logic [W-1:0] e_r1;
  logic [W-1:0] e_r2;
  logic         e_b1;
  logic         e_b2;
  logic         e_err;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
    e_r1 = '0; e_r2 = '0; e_b1 = 1'b0; e_b2 = 1'b0; e_err = 1'b0;
  endtask

  // Applies one clock edge of architectural behaviour; reads see post-edge state.
  task automatic model_edge();
    logic [W-1:0] merged;
    logic         wr_ok;
    logic         err;
    wr_ok = regWrEn && (regToWrite != 0);
    err   = reserveEn && (regToReserve != 0) && m_busy[regToReserve] &&
            !(wr_ok && (regToWrite == regToReserve));
    if (wr_ok) begin
      merged = m_mem[regToWrite];
      for (int l = 0; l < LN; l++)
        if (wrMask[l]) merged[l*LW +: LW] = dataIn[l*LW +: LW];
      m_mem[regToWrite]  = merged;
      m_busy[regToWrite] = 1'b0;
    end
    if (reserveEn && (regToReserve != 0) && !err) m_busy[regToReserve] = 1'b1;
    e_err = err;
    if (rdEn) begin
      e_r1 = (rSel1 == 0) ? '0 : m_mem[rSel1];
      e_b1 = (rSel1 == 0) ? 1'b0 : m_busy[rSel1];
      e_r2 = (rSel2 == 0) ? '0 : m_mem[rSel2];
      e_b2 = (rSel2 == 0) ? 1'b0 : m_busy[rSel2];
    end
  endtask

  task automatic idle();
    regWrEn = 1'b0; regToWrite = '0; wrMask = '0; dataIn = '0;
    rdEn = 1'b0; rSel1 = '0; rSel2 = '0;
    reserveEn = 1'b0; regToReserve = '0;
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, ".r1"},  reg1Out, e_r1);
    check({tag, ".r2"},  reg2Out, e_r2);
    check({tag, ".b1"},  W'(busy1), W'(e_b1));
    check({tag, ".b2"},  W'(busy2), W'(e_b2));
    check({tag, ".err"}, W'(reserveErr), W'(e_err));
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.r1", reg1Out, '0);
    check("rst.b1", W'(busy1), '0);
    check("rst.err", W'(reserveErr), '0);
    reset = 1'b1;

    for (int r = 0; r < NR; r++) begin
      rdEn = 1'b1; rSel1 = IW'(r); rSel2 = IW'(r);
      cycle("init_read");
    end

    regWrEn = 1'b1; regToWrite = 3'd1; wrMask = 4'hF; dataIn = 32'hFEDCBA98;
    rdEn = 1'b1; rSel1 = 3'd1; rSel2 = 3'd2;
    cycle("bypass");
    check("bypass.lit", reg1Out, 32'hFEDCBA98);

    regWrEn = 1'b1; regToWrite = 3'd1; wrMask = 4'b0101; dataIn = 32'h11223344;
    cycle("mask_wr");
    rdEn = 1'b1; rSel1 = 3'd1; rSel2 = 3'd1;
    cycle("mask_rd");
    check("mask.lit1", reg1Out, 32'hFE22BA44);
    check("mask.lit2", reg2Out, 32'hFE22BA44);

    regWrEn = 1'b1; regToWrite = 3'd0; wrMask = 4'hF; dataIn = 32'hFFFFFFFF;
    reserveEn = 1'b1; regToReserve = 3'd0; rdEn = 1'b1; rSel1 = 3'd0;
    cycle("zero_reg");

    reserveEn = 1'b1; regToReserve = 3'd3; rdEn = 1'b1; rSel2 = 3'd3;
    cycle("rsv3");
    check("rsv3.lit", W'(busy2), W'(1'b1));
    reserveEn = 1'b1; regToReserve = 3'd3;
    cycle("rsv3_again");
    check("rsv3_err.lit", W'(reserveErr), W'(1'b1));
    cycle("err_drop");
    regWrEn = 1'b1; regToWrite = 3'd3; wrMask = 4'h0; dataIn = 32'hDEADBEEF;
    rdEn = 1'b1; rSel2 = 3'd3;
    cycle("wr3_nomask");
    regWrEn = 1'b1; regToWrite = 3'd3; wrMask = 4'hF; dataIn = 32'h0BADF00D;
    reserveEn = 1'b1; regToReserve = 3'd3; rdEn = 1'b1; rSel2 = 3'd3;
    cycle("wr_rsv3");
    check("wr_rsv3.lit", reg2Out, 32'h0BADF00D);

    regWrEn = 1'b1; regToWrite = 3'd5; wrMask = 4'hF; dataIn = 32'hA5A5A5A5;
    reserveEn = 1'b1; regToReserve = 3'd6;
    cycle("wr5");
    rdEn = 1'b1; rSel1 = 3'd5;
    cycle("rd5");
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_rst.r1", reg1Out, '0);
    check("async_rst.r2", reg2Out, '0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int r = 0; r < NR; r++) begin
      rdEn = 1'b1; rSel1 = 3'd5; rSel2 = IW'(r);
      cycle("post_rst");
    end

    for (int i = 0; i < 400; i++) begin
      regWrEn      = ($urandom_range(0, 1) == 1);
      regToWrite   = IW'($urandom_range(0, NR - 1));
      wrMask       = LN'($urandom);
      dataIn       = W'($urandom);
      rdEn         = ($urandom_range(0, 3) != 0);
      rSel1        = IW'($urandom_range(0, NR - 1));
      rSel2        = ($urandom_range(0, 3) == 0) ? regToWrite : IW'($urandom_range(0, NR - 1));
      reserveEn    = ($urandom_range(0, 2) == 0);
      regToReserve = ($urandom_range(0, 3) == 0) ? regToWrite : IW'($urandom_range(0, NR - 1));
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
